// File: rtl/stream_rr_arb.sv
// ============================================================================
// Module      : stream_rr_arb
// Description : Round-robin arbiter for N_INP valid/ready streams onto one
//               output stream. Grant, payload and ready paths are purely
//               combinational (zero latency); only the round-robin pointer
//               (and the optional lock) are registered.
//               Optional feature macro: STREAM_RR_ARB_LOCK_EN
//                 defined   -> a stalled grant is locked until it transfers
//                 undefined -> grant is recomputed every cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_rr_arb #(
  parameter type         DATA_T    = logic,
  parameter int unsigned N_INP     = 2,
  parameter int unsigned LOG_N_INP = $clog2(N_INP)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  DATA_T [N_INP-1:0]    inp_data_i,
  input  logic  [N_INP-1:0]    inp_valid_i,
  output logic  [N_INP-1:0]    inp_ready_o,
  output DATA_T                oup_data_o,
  output logic                 oup_valid_o,
  input  logic                 oup_ready_i,
  output logic [LOG_N_INP-1:0] sel_o
);

  // Highest legal index; the pointer wraps from here back to zero, which
  // keeps non-power-of-two input counts from ever reaching N_INP.
  localparam logic [LOG_N_INP-1:0] c_LAST_IDX = LOG_N_INP'(N_INP - 1);
  // One extra bit so rr + offset cannot overflow before the modulo fold.
  localparam logic [LOG_N_INP:0]   c_N_WIDE   = (LOG_N_INP + 1)'(N_INP);

  logic [LOG_N_INP-1:0] r_rr;        // round-robin search start
  logic [LOG_N_INP-1:0] w_rr_sel;    // round-robin pick from r_rr
  logic                 w_any_valid; // at least one input requesting
  logic [LOG_N_INP-1:0] w_sel;       // effective grant index
  logic                 w_xfer;      // handshake completes this cycle
  logic [LOG_N_INP-1:0] w_rr_next;   // pointer value after a transfer

  assign w_any_valid = |inp_valid_i;

  // Cyclic first-valid search starting at r_rr; falls back to r_rr itself
  // when nothing is valid so sel_o exposes the pointer while idle.
  always_comb begin
    logic [LOG_N_INP:0]   w_sum;
    logic [LOG_N_INP-1:0] w_idx;
    logic                 w_found;
    w_rr_sel = r_rr;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < N_INP; k++) begin
      w_sum = {1'b0, r_rr} + (LOG_N_INP + 1)'(k);
      if (w_sum >= c_N_WIDE) begin
        w_sum = w_sum - c_N_WIDE;
      end
      w_idx = w_sum[LOG_N_INP-1:0];
      if (!w_found && inp_valid_i[w_idx]) begin
        w_rr_sel = w_idx;
        w_found  = 1'b1;
      end
    end
  end

`ifdef STREAM_RR_ARB_LOCK_EN
  logic                 r_lock;      // a stalled grant is being held
  logic [LOG_N_INP-1:0] r_lock_idx;  // index held while r_lock is set

  // While locked the held index wins over any newly arriving requester.
  assign w_sel = r_lock ? r_lock_idx : w_rr_sel;
`else
  assign w_sel = w_rr_sel;
`endif

  assign sel_o       = w_sel;
  assign oup_data_o  = inp_data_i[w_sel];
  assign oup_valid_o = inp_valid_i[w_sel];
  assign w_xfer      = oup_valid_o & oup_ready_i;
  assign w_rr_next   = (w_sel == c_LAST_IDX) ? '0 : w_sel + 1'b1;

  // Route downstream ready back to the granted input only; idle means no ready.
  always_comb begin
    inp_ready_o = '0;
    if (w_any_valid) begin
      inp_ready_o[w_sel] = oup_ready_i;
    end
  end

  // Advance the pointer past the winner on each completed transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr <= '0;
    end else if (w_xfer) begin
      r_rr <= w_rr_next;
    end
  end

`ifdef STREAM_RR_ARB_LOCK_EN
  // Hold a stalled grant until it transfers so the payload cannot switch.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_xfer) begin
      r_lock     <= 1'b0;
    end else if (oup_valid_o && !oup_ready_i) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_sel;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_rr_arb.sv
// ============================================================================
// Module      : tb_stream_rr_arb
// Description : Self-checking bench for stream_rr_arb (N_INP=4 and N_INP=3).
//               Expectations come from a reference model that follows the
//               STREAM_RR_ARB_LOCK_EN setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_rr_arb;

  localparam int N = 4;
  typedef logic [7:0] byte_t;

`ifdef STREAM_RR_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  // 4-input instance
  byte_t [3:0] d4;
  logic  [3:0] v4;
  logic  [3:0] rdy4;
  byte_t       od4;
  logic        ov4;
  logic        r4;
  logic  [1:0] sel4;

  // 3-input instance
  byte_t [2:0] d3;
  logic  [2:0] v3;
  logic  [2:0] rdy3;
  byte_t       od3;
  logic        ov3;
  logic        r3;
  logic  [1:0] sel3;

  always #5 clk = ~clk;

  stream_rr_arb #(.DATA_T(byte_t), .N_INP(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst),
    .inp_data_i(d4), .inp_valid_i(v4), .inp_ready_o(rdy4),
    .oup_data_o(od4), .oup_valid_o(ov4), .oup_ready_i(r4), .sel_o(sel4)
  );

  stream_rr_arb #(.DATA_T(byte_t), .N_INP(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .inp_data_i(d3), .inp_valid_i(v3), .inp_ready_o(rdy3),
    .oup_data_o(od3), .oup_valid_o(ov3), .oup_ready_i(r3), .sel_o(sel3)
  );

  typedef struct {
    logic [1:0] sel;
    logic       valid;
    logic [3:0] ready;
    byte_t      data;
  } exp_t;

  exp_t q_exp[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Reference state for the 4-input instance
  int   m_rr       = 0;
  bit   m_lock     = 1'b0;
  int   m_lock_idx = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return start;
  endfunction

  // One cycle on the 4-input DUT: drive at negedge, push the model's
  // expectation, pop and compare once outputs settle, then step the model.
  task automatic drive(input logic [3:0] vld, input logic rdy, input string tag,
                       output logic [1:0] got_sel);
    exp_t e;
    exp_t g;
    int   s;
    @(negedge clk);
    v4 = vld;
    r4 = rdy;
    for (int i = 0; i < N; i++) d4[i] = byte_t'($urandom);
    s       = (LOCK_EN && m_lock) ? m_lock_idx : rr_pick(vld, m_rr);
    e.sel   = 2'(s);
    e.valid = vld[s];
    e.ready = (|vld && rdy) ? 4'(1 << s) : 4'b0000;
    e.data  = d4[s];
    q_exp.push_back(e);
    #1;
    g = q_exp.pop_front();
    check({tag, ".sel"},   32'(sel4), 32'(g.sel));
    check({tag, ".valid"}, 32'(ov4),  32'(g.valid));
    check({tag, ".ready"}, 32'(rdy4), 32'(g.ready));
    if (g.valid) check({tag, ".data"}, 32'(od4), 32'(g.data));
    got_sel = sel4;
    @(posedge clk);
    if (g.valid && rdy) begin
      m_rr   = (s + 1) % N;
      m_lock = 1'b0;
    end else if (LOCK_EN && g.valid && !rdy) begin
      m_lock     = 1'b1;
      m_lock_idx = s;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] s;
    rst  = 1'b1;
    v4   = '0; r4 = 1'b0; d4 = '0;
    v3   = '0; r3 = 1'b0; d3 = '0;

    // Reset state
    #3;
    check("rst.sel", 32'(sel4), 32'd0);
    check("rst.valid", 32'(ov4), 32'd0);
    check("rst.ready", 32'(rdy4), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All valid, always ready: strict rotation 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 1'b1, "rot", s);
      check("rot.seq", 32'(s), 32'(k % 4));
    end

    // Single requester at 2, pointer to 3, then wrap to 0
    drive(4'b0100, 1'b1, "one2", s);
    check("one2.sel", 32'(s), 32'd2);
    drive(4'b0000, 1'b1, "idle3", s);
    check("idle3.rr", 32'(s), 32'd3);
    drive(4'b0001, 1'b1, "wrap0", s);
    check("wrap0.sel", 32'(s), 32'd0);
    drive(4'b0000, 1'b1, "idle1", s);
    check("idle1.rr", 32'(s), 32'd1);

    // Bring pointer to 0, then stall with a late lower-index requester
    drive(4'b1000, 1'b1, "to0", s);
    drive(4'b0010, 1'b0, "stall1", s);
    check("stall1.sel", 32'(s), 32'd1);
    drive(4'b0011, 1'b0, "stall2", s);
    check("stall2.sel", 32'(s), LOCK_EN ? 32'd1 : 32'd0);
    drive(4'b0011, 1'b1, "release", s);
    check("release.sel", 32'(s), LOCK_EN ? 32'd1 : 32'd0);
    drive(4'b0000, 1'b0, "after", s);
    check("after.rr", 32'(s), LOCK_EN ? 32'd2 : 32'd1);

    // Asynchronous reset in the middle of a stall
    drive(4'b0010, 1'b0, "prerst", s);
    @(negedge clk);
    v4 = 4'b0000;
    #2 rst = 1'b1;
    #1 check("arst.rr", 32'(sel4), 32'd0);
    v4 = 4'b1000;
    #1 check("arst.sel3", 32'(sel4), 32'd3);
    v4 = 4'b1001;
    #1 check("arst.sel0", 32'(sel4), 32'd0);
    v4 = 4'b0000;
    @(negedge clk);
    rst        = 1'b0;
    m_rr       = 0;
    m_lock     = 1'b0;
    m_lock_idx = 0;
    drive(4'b1111, 1'b1, "postrst", s);
    check("postrst.sel", 32'(s), 32'd0);

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rnd", s);
    end
    @(negedge clk);
    v4 = '0;
    r4 = 1'b0;

    // Three inputs: transfer at index 2 wraps to 0
    @(negedge clk);
    v3 = 3'b100; r3 = 1'b1; d3 = {8'hC2, 8'hB1, 8'hA0};
    #1;
    check("n3.sel", 32'(sel3), 32'd2);
    check("n3.ready", 32'(rdy3), 32'b100);
    check("n3.data", 32'(od3), 32'hC2);
    @(negedge clk);
    v3 = 3'b000;
    #1 check("n3.rr", 32'(sel3), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      v3 = 3'b111;
      #1 check("n3.rot", 32'(sel3), 32'(k % 3));
    end
    @(negedge clk);
    v3 = 3'b000;
    r3 = 1'b0;

    if (q_exp.size() != 0) check("sb.empty", 32'(q_exp.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
